// File: rtl/platform_renderer_pkg.sv
// platform_renderer_pkg: shared descriptor and pipeline types for the platform tile-strip renderer.
package platform_renderer_pkg;

    localparam int PLATFORM_IDX_W = 4;
    localparam int TILE_W_DEFAULT = 64;
    localparam int TILE_H_DEFAULT = 32;
    localparam int HOR_PIXELS     = 1024;
    localparam int VER_PIXELS     = 768;

    typedef struct packed {
        logic [10:0] y_top;
        logic [10:0] x_start;
        logic [10:0] x_end;
        logic        en;
        logic        dir;
    } platform_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_sig_t;

    typedef struct packed {
        vga_sig_t sig;
        logic     hit;
        logic     start;
    } pipe_t;

    // A disabled descriptor parked just outside the visible area.
    function automatic platform_t platform_off();
        platform_t p;
        p.y_top   = 11'(VER_PIXELS);
        p.x_start = 11'(HOR_PIXELS);
        p.x_end   = 11'(HOR_PIXELS);
        p.en      = 1'b0;
        p.dir     = 1'b0;
        return p;
    endfunction

endpackage

// File: rtl/vga_if.sv
// vga_if: VGA timing plus pixel colour, passed between pipeline stages.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/platform_renderer_delay.sv
// platform_renderer_delay: fixed-depth register delay line with asynchronous clear.
module platform_renderer_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Shift every stage one step towards the output.
    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Delay-line registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/platform_renderer.sv
// platform_renderer: overlays tile-high platforms from a shared tile ROM onto the background.
// Optional texture scrolling is built when PLATFORM_SCROLL_EN is defined.
module platform_renderer
    import platform_renderer_pkg::*;
#(
    parameter int          NUM_PLATFORMS   = 4,
    parameter int          TILE_W          = TILE_W_DEFAULT,
    parameter int          TILE_H          = TILE_H_DEFAULT,
    parameter int          SCROLL_DIV      = 4,
    parameter logic [11:0] TRANSPARENT_KEY = 12'hF0F
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start_game,
    input  logic                                      animation,
    input  logic                                      wr_en,
    input  logic [PLATFORM_IDX_W-1:0]                 wr_idx,
    input  platform_t                                 wr_data,
    input  logic [11:0]                               rgb_pixel,
    output logic [$clog2(TILE_H)+$clog2(TILE_W)-1:0]  pixel_addr,
    vga_if.in                                         in,
    vga_if.out                                        out
);

    localparam int ROW_W  = $clog2(TILE_H);
    localparam int COL_W  = $clog2(TILE_W);
    localparam int ADDR_W = ROW_W + COL_W;

    logic              vsync_prev_q, vsync_prev_d;
    logic              tick;
    platform_t         shadow_q [NUM_PLATFORMS];
    platform_t         shadow_d [NUM_PLATFORMS];
    platform_t         active_q [NUM_PLATFORMS];
    platform_t         active_d [NUM_PLATFORMS];
    logic              hit;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] pixel_addr_q, pixel_addr_d;
    pipe_t             pipe_in, pipe_dly;
    vga_sig_t          out_q, out_d;

    assign tick = in.vsync & ~vsync_prev_q;

    // Shadow bank takes writes; active bank copies the pre-write shadow on the frame tick.
    always_comb begin
        vsync_prev_d = in.vsync;
        shadow_d     = shadow_q;
        active_d     = active_q;
        if (tick) begin
            active_d = shadow_q;
        end
        for (int i = 0; i < NUM_PLATFORMS; i++) begin
            if (wr_en && wr_idx == PLATFORM_IDX_W'(i)) begin
                shadow_d[i] = wr_data;
            end
        end
    end

`ifdef PLATFORM_SCROLL_EN
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    logic [COL_W-1:0] offset_q [NUM_PLATFORMS];
    logic [COL_W-1:0] offset_d [NUM_PLATFORMS];
    logic [DIV_W-1:0] div_q, div_d;

    // Frame divider steps on ticks while animating; on wrap every enabled platform scrolls one pixel.
    always_comb begin
        div_d    = div_q;
        offset_d = offset_q;
        if (tick && animation) begin
            if (div_q == DIV_W'(SCROLL_DIV - 1)) begin
                div_d = '0;
                for (int i = 0; i < NUM_PLATFORMS; i++) begin
                    if (active_q[i].en) begin
                        offset_d[i] = active_q[i].dir ? offset_q[i] - COL_W'(1)
                                                      : offset_q[i] + COL_W'(1);
                    end
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Scroll state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            for (int i = 0; i < NUM_PLATFORMS; i++) begin
                offset_q[i] <= '0;
            end
        end else begin
            div_q    <= div_d;
            offset_q <= offset_d;
        end
    end
`else
    logic                     unused_anim;
    logic [NUM_PLATFORMS-1:0] unused_dir;

    assign unused_anim = animation;

    // Scroll direction has no effect without the scroll logic.
    always_comb begin
        for (int i = 0; i < NUM_PLATFORMS; i++) begin
            unused_dir[i] = active_q[i].dir;
        end
    end
`endif

    // Hit test on the incoming pixel; scanning downwards lets the lowest index win.
    always_comb begin
        hit = 1'b0;
        row = '0;
        col = '0;
        for (int i = NUM_PLATFORMS - 1; i >= 0; i--) begin
            if (active_q[i].en &&
                in.vcount >= active_q[i].y_top &&
                (in.vcount - active_q[i].y_top) < 11'(TILE_H) &&
                in.hcount >= active_q[i].x_start &&
                in.hcount < active_q[i].x_end) begin
                hit = 1'b1;
                row = in.vcount[ROW_W-1:0] - active_q[i].y_top[ROW_W-1:0];
`ifdef PLATFORM_SCROLL_EN
                col = in.hcount[COL_W-1:0] - active_q[i].x_start[COL_W-1:0] + offset_q[i];
`else
                col = in.hcount[COL_W-1:0] - active_q[i].x_start[COL_W-1:0];
`endif
            end
        end
        pixel_addr_d = hit ? {row, col} : pixel_addr_q;
    end

    // Descriptor banks, tick edge detector and ROM address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_q <= 1'b0;
            pixel_addr_q <= '0;
            for (int i = 0; i < NUM_PLATFORMS; i++) begin
                shadow_q[i] <= platform_off();
                active_q[i] <= platform_off();
            end
        end else begin
            vsync_prev_q <= vsync_prev_d;
            pixel_addr_q <= pixel_addr_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
        end
    end

    assign pixel_addr = pixel_addr_q;

    assign pipe_in = {in.hcount, in.vcount, in.hsync, in.vsync, in.hblnk, in.vblnk,
                      in.rgb, hit, start_game};

    platform_renderer_delay #(
        .WIDTH ($bits(pipe_t)),
        .DEPTH (2)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (pipe_in),
        .dout  (pipe_dly)
    );

    // Compose the final colour once the ROM data lines up with the delayed hit flag.
    always_comb begin
        out_d = pipe_dly.sig;
        if (pipe_dly.sig.hblnk || pipe_dly.sig.vblnk) begin
            out_d.rgb = 12'h000;
        end else if (!pipe_dly.start) begin
            out_d.rgb = pipe_dly.sig.rgb;
        end else if (pipe_dly.hit && rgb_pixel != TRANSPARENT_KEY) begin
            out_d.rgb = rgb_pixel;
        end else begin
            out_d.rgb = pipe_dly.sig.rgb;
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out.hcount = out_q.hcount;
    assign out.vcount = out_q.vcount;
    assign out.hsync  = out_q.hsync;
    assign out.vsync  = out_q.vsync;
    assign out.hblnk  = out_q.hblnk;
    assign out.vblnk  = out_q.vblnk;
    assign out.rgb    = out_q.rgb;

endmodule

// File: doc/platform_renderer.md
# platform_renderer

Parametrised tile-strip renderer for the VGA pipeline. It overlays up to NUM_PLATFORMS horizontal platforms, each one tile high, onto the incoming background, using one shared tile ROM. Platform geometry is runtime-configurable through a write port with frame-synchronous commit. Each platform can scroll its texture independently once per frame divider period. It sits after the background stage and before the sprite stages, on `vga_if` in/out.

## Interface
Parameters:
- NUM_PLATFORMS, 4: number of platform descriptors (1..16).
- TILE_W, 64: tile width in pixels, power of two.
- TILE_H, 32: tile height in pixels, power of two.
- SCROLL_DIV, 4: frames per scroll step (≥1).
- TRANSPARENT_KEY, 12'hF0F: ROM colour treated as see-through.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start_game  in  1  enables platform drawing; when 0 the background passes through.
- animation  in  1  enables scroll advance.
- wr_en  in  1  descriptor write strobe.
- wr_idx  in  4  descriptor index.
- wr_data  in  platform_t  descriptor value.
- rgb_pixel  in  12  tile ROM data, 1-cycle read latency.
- pixel_addr  out  $clog2(TILE_H)+$clog2(TILE_W)  tile ROM address, {row, col}.
- in  vga_if.in  timing and background.
- out  vga_if.out  timing and composed rgb.

## Operation
- Descriptor platform_t fields:
  - y_top[10:0]
  - x_start[10:0]
  - x_end[10:0] (exclusive)
  - en
  - dir (0 = +1, 1 = −1)
- Shadow/active descriptor banks. wr_en writes shadow[wr_idx]. Writes with wr_idx ≥ NUM_PLATFORMS are ignored.
- Frame tick: rising edge of in.vsync, detected with a registered previous value. On the tick, active ← shadow for all entries.
- Same-cycle conflict: if wr_en coincides with the tick, the commit copies the pre-write shadow, and the new write commits on the next tick.
- Hit test on input coordinates (stage 0): platform i hits when
  - en = 1, and
  - y_top ≤ vcount < y_top+TILE_H, and
  - x_start ≤ hcount < x_end.
- Overlap priority: the lowest index wins.
- ROM address for the winning platform:
  - row = (vcount − y_top) truncated to $clog2(TILE_H) bits.
  - col = (hcount − x_start + offset[i]) mod TILE_W.
- On no hit, pixel_addr holds its value.
- Scroll state:
  - Per-platform offset[i] is $clog2(TILE_W) bits.
  - A frame divider counts 0..SCROLL_DIV−1 on ticks, but only while animation = 1; it freezes otherwise.
  - On the tick where the divider wraps, each enabled platform does offset ± 1 mod TILE_W (wraps 63↔0 for TILE_W = 64).
  - Committing a descriptor does not clear its offset.
- Output rgb:
  - blank (delayed hblnk|vblnk) → 12'h000;
  - else if !start_game_d → delayed background;
  - else if hit_d and rgb_pixel ≠ TRANSPARENT_KEY → rgb_pixel;
  - else → delayed background.
- start_game is sampled in stage 0 and delayed with the hit flag, so mid-frame toggles are pixel-aligned.

## Timing
- Stage 0: hit/address computed combinationally, then registered to pixel_addr.
- Stage 1: the ROM presents rgb_pixel.
- Stage 2: the output register.
- Total in→out latency is 3 cycles for all timing signals and rgb. The hit flag, start_game and background rgb go through a 2-cycle delay line.
- The frame-tick commit and scroll updates take effect from the first pixel after the tick edge. The vsync edge falls in vertical blanking, so there is no tearing.
- Reset values:
  - out.* (hcount, vcount, syncs, blanks, rgb) = 0;
  - pixel_addr = 0;
  - all descriptors en = 0 (shadow and active);
  - offsets = 0;
  - divider = 0;
  - delay lines = 0.
- Reset mid-frame: outputs drop to 0 asynchronously, and rendering resumes with all platforms disabled.

## Configuration
- PLATFORM_SCROLL_EN defined: offset registers, frame divider and the dir field are active, as described above.
- Not defined: there is no scroll logic, col = (hcount − x_start) mod TILE_W, and the animation and dir inputs are ignored. Latency is unchanged.

## Structure
- vgaPkg holds:
  - platform_t;
  - PLATFORM_IDX_W = 4;
  - default TILE_W/TILE_H;
  - existing HOR_PIXELS/VER_PIXELS for descriptor defaults.
- Sub-module: the existing `delay` is used for the 2-cycle timing/background/hit pipeline. No other children.

## Test plan
- Single platform: y_top = 100, x_start = 0, x_end = 1024, en = 1, one commit. At pixel (5,110), expect pixel_addr = {5'd10, 6'd5} and out.rgb = ROM value 3 cycles after input.
- Overlap: platforms 0 and 1 share rows 100..131. Expect platform 0's address wins. With the ROM returning 12'hF0F, expect the background rgb instead.
- Scroll (macro on): SCROLL_DIV = 2, animation = 1, dir = 0, offset = 63. After 2 ticks expect offset = 0 and col = (hcount − x_start) mod 64. With dir = 1 from 0, expect 63.
- Commit timing: write platform 2 mid-frame. Expect no change until the vsync rising edge. With a write on the tick cycle, expect it to appear one frame later. wr_idx = 9 is ignored.
- Gating: start_game = 0 → out.rgb equals input background (delayed 3). Blanking → 12'h000. animation = 0 → offsets and divider frozen.
- Reset: assert rst_n low mid-line. Expect all outputs 0 immediately and no platform drawn after release until a new write and commit.
